// File: rtl/frame_parser_if.sv
// Stream-in / record-out bundle between an upstream word source and the header parser.
// The parser side takes the slave modport; the source/consumer side takes master.
interface frame_parser_if;
  logic [31:0] data_in;
  logic        sop;
  logic        eop;
  logic [1:0]  empty;
  logic        err;
  logic        valid;
  logic        ready;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [15:0] ethertype;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic [15:0] src_port;
  logic [15:0] dst_port;
  logic        is_ipv4;
  logic        has_ports;
  logic        match_mac;
  logic        match_ip;
  logic        match_port;
  logic        hdr_valid;
  logic        hdr_err;
  logic        hdr_ack;

  modport master (
    output data_in, sop, eop, empty, err, valid, hdr_ack,
    input  ready, dst_mac, src_mac, ethertype, src_ip, dst_ip, src_port, dst_port,
    input  is_ipv4, has_ports, match_mac, match_ip, match_port, hdr_valid, hdr_err
  );

  modport slave (
    input  data_in, sop, eop, empty, err, valid, hdr_ack,
    output ready, dst_mac, src_mac, ethertype, src_ip, dst_ip, src_port, dst_port,
    output is_ipv4, has_ports, match_mac, match_ip, match_port, hdr_valid, hdr_err
  );
endinterface

// File: rtl/frame_parser.sv
// Extracts Ethernet/IPv4/L4 header fields from a 32-bit stream and flags address matches.
// Record valid 1 cycle after the eop beat; ready stays low while a record waits for hdr_ack.
module frame_parser (
  input  logic          clk,
  input  logic          n_rst,
  frame_parser_if.slave s,
  input  logic [47:0]   flagged_mac,
  input  logic [31:0]   flagged_ip,
  input  logic [15:0]   flagged_port
);
  typedef enum logic [1:0] {IDLE, HDR, SKIP, DONE} state_t;

  state_t      state;
  logic [3:0]  w;
  logic [3:0]  ihl;
  logic [7:0]  proto;
  logic        got9;
  logic        err_seen;
  logic [47:0] dmac, smac;
  logic [15:0] et, sp, dp;
  logic [31:0] sip, dip;
  logic        ipv4_q, ports_q, mm_q, mi_q, mp_q, valid_q, herr_q;

  logic        acc, start, in_frame, cap, fin;
  logic [3:0]  idx, n_ihl;
  logic [7:0]  n_proto;
  logic        n_got9, n_err;
  logic [47:0] n_dmac, n_smac;
  logic [15:0] n_et, n_sp, n_dp;
  logic [31:0] n_sip, n_dip;
  logic        rec_err, rec_ip4, rec_ports, rec_mm, rec_mi, rec_mp;
  logic        unused_empty;

  assign unused_empty = ^s.empty;
  assign s.ready      = (state != DONE);

  // Next-field view includes the current beat so the eop edge sees the complete header.
  always_comb begin
    acc      = s.valid && s.ready;
    start    = acc && s.sop;
    in_frame = acc && (s.sop || state == HDR || state == SKIP);
    cap      = acc && (s.sop || state == HDR);
    fin      = in_frame && s.eop;
    idx      = s.sop ? 4'd0 : w;
    n_dmac   = start ? '0 : dmac;
    n_smac   = start ? '0 : smac;
    n_et     = start ? '0 : et;
    n_ihl    = start ? '0 : ihl;
    n_proto  = start ? '0 : proto;
    n_sip    = start ? '0 : sip;
    n_dip    = start ? '0 : dip;
    n_sp     = start ? '0 : sp;
    n_dp     = start ? '0 : dp;
    if (cap) begin
      case (idx)
        4'd0: n_dmac[47:16] = s.data_in;
        4'd1: begin n_dmac[15:0] = s.data_in[31:16]; n_smac[47:32] = s.data_in[15:0]; end
        4'd2: n_smac[31:0] = s.data_in;
        4'd3: begin n_et = s.data_in[31:16]; n_ihl = s.data_in[11:8]; end
        4'd5: n_proto = s.data_in[7:0];
        4'd6: n_sip[31:16] = s.data_in[15:0];
        4'd7: begin n_sip[15:0] = s.data_in[31:16]; n_dip[31:16] = s.data_in[15:0]; end
        4'd8: begin n_dip[15:0] = s.data_in[31:16]; n_sp = s.data_in[15:0]; end
        4'd9: n_dp = s.data_in[31:16];
        default: ;
      endcase
    end
    n_got9    = (start ? 1'b0 : got9) | (cap && idx == 4'd9);
    n_err     = (start ? 1'b0 : err_seen) | (in_frame && s.err);
    rec_err   = n_err || (idx < 4'd3);
    rec_ip4   = !rec_err && (n_et == 16'h0800) && (n_ihl == 4'd5);
    rec_ports = rec_ip4 && (n_proto == 8'd6 || n_proto == 8'd17) && n_got9;
    rec_mm    = !rec_err && (n_dmac == flagged_mac || n_smac == flagged_mac);
    rec_mi    = rec_ip4 && (n_sip == flagged_ip || n_dip == flagged_ip);
    rec_mp    = rec_ports && (n_sp == flagged_port || n_dp == flagged_port);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;  w <= '0;  ihl <= '0;  proto <= '0;  got9 <= 1'b0;  err_seen <= 1'b0;
      dmac <= '0;  smac <= '0;  et <= '0;  sip <= '0;  dip <= '0;  sp <= '0;  dp <= '0;
      ipv4_q <= 1'b0;  ports_q <= 1'b0;  mm_q <= 1'b0;  mi_q <= 1'b0;  mp_q <= 1'b0;
      valid_q <= 1'b0;  herr_q <= 1'b0;
    end else if (state == DONE) begin
      if (s.hdr_ack) begin
        state   <= IDLE;
        valid_q <= 1'b0;
      end
    end else if (in_frame) begin
      dmac <= n_dmac;  smac <= n_smac;  et <= n_et;  ihl <= n_ihl;  proto <= n_proto;
      sip <= n_sip;  dip <= n_dip;  sp <= n_sp;  dp <= n_dp;
      got9 <= n_got9;  err_seen <= n_err;
      w <= start ? 4'd1 : ((w == 4'd15) ? w : w + 4'd1);
      if (fin) begin
        state   <= DONE;
        valid_q <= 1'b1;
        herr_q  <= rec_err;
        ipv4_q  <= rec_ip4;  ports_q <= rec_ports;
        mm_q    <= rec_mm;   mi_q    <= rec_mi;    mp_q <= rec_mp;
      end else if (start) begin
        state  <= HDR;
        herr_q <= 1'b0;
        ipv4_q <= 1'b0;  ports_q <= 1'b0;  mm_q <= 1'b0;  mi_q <= 1'b0;  mp_q <= 1'b0;
      end else if (state == HDR && w == 4'd9) begin
        state <= SKIP;
      end
    end
  end

  assign s.dst_mac    = dmac;
  assign s.src_mac    = smac;
  assign s.ethertype  = et;
  assign s.src_ip     = sip;
  assign s.dst_ip     = dip;
  assign s.src_port   = sp;
  assign s.dst_port   = dp;
  assign s.is_ipv4    = ipv4_q;
  assign s.has_ports  = ports_q;
  assign s.match_mac  = mm_q;
  assign s.match_ip   = mi_q;
  assign s.match_port = mp_q;
  assign s.hdr_valid  = valid_q;
  assign s.hdr_err    = herr_q;
endmodule

// File: tb/tb_frame_parser.sv
// Scoreboard bench for frame_parser: byte-level header model feeds an expected-record queue,
// an independent monitor pops and compares each record and drives hdr_ack.
module tb_frame_parser;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic [47:0] flagged_mac = '0;
  logic [31:0] flagged_ip = '0;
  logic [15:0] flagged_port = '0;
  always #5 clk = ~clk;

  frame_parser_if bus();
  frame_parser dut (
    .clk(clk), .n_rst(n_rst), .s(bus),
    .flagged_mac(flagged_mac), .flagged_ip(flagged_ip), .flagged_port(flagged_port)
  );

  typedef struct {
    logic [47:0] dmac, smac;
    logic [15:0] et;
    logic [31:0] sip, dip;
    logic [15:0] sp, dp;
    bit ipv4, ports, mm, mi, mp, herr;
    int cyc;
  } rec_t;

  rec_t exp_q[$];
  logic [31:0] fw[$];
  bit   f_open = 0, f_err = 0;
  int   n_cmp = 0, n_bad = 0, cyc = 0, ack_delay_next = -1;
  logic [7:0] fb [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [214:0] snap();
    return {bus.dst_mac, bus.src_mac, bus.ethertype, bus.src_ip, bus.dst_ip, bus.src_port,
            bus.dst_port, bus.is_ipv4, bus.has_ports, bus.match_mac, bus.match_ip,
            bus.match_port, bus.hdr_err, bus.hdr_valid};
  endfunction

  task automatic check_snap(input string name, input logic [214:0] act, input logic [214:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: view the accepted words as wire bytes and read fields at their header offsets.
  task automatic push_expected();
    logic [7:0] mb [0:39];
    rec_t r;
    int n = fw.size();
    for (int i = 0; i < 40; i++) mb[i] = 8'h00;
    for (int i = 0; i < n && i < 10; i++) begin
      mb[4*i] = fw[i][31:24]; mb[4*i+1] = fw[i][23:16];
      mb[4*i+2] = fw[i][15:8]; mb[4*i+3] = fw[i][7:0];
    end
    r.dmac  = {mb[0], mb[1], mb[2], mb[3], mb[4], mb[5]};
    r.smac  = {mb[6], mb[7], mb[8], mb[9], mb[10], mb[11]};
    r.et    = {mb[12], mb[13]};
    r.sip   = {mb[26], mb[27], mb[28], mb[29]};
    r.dip   = {mb[30], mb[31], mb[32], mb[33]};
    r.sp    = {mb[34], mb[35]};
    r.dp    = {mb[36], mb[37]};
    r.herr  = f_err || (n < 4);
    r.ipv4  = !r.herr && r.et == 16'h0800 && mb[14][3:0] == 4'd5;
    r.ports = r.ipv4 && (mb[23] == 8'd6 || mb[23] == 8'd17) && n >= 10;
    r.mm    = !r.herr && (r.dmac == flagged_mac || r.smac == flagged_mac);
    r.mi    = r.ipv4 && (r.sip == flagged_ip || r.dip == flagged_ip);
    r.mp    = r.ports && (r.sp == flagged_port || r.dp == flagged_port);
    r.cyc   = cyc;
    exp_q.push_back(r);
  endtask

  task automatic model_beat(input logic [31:0] d, input bit s, input bit e, input bit er);
    if (s) begin fw.delete(); f_err = 0; f_open = 1; end
    if (f_open) begin
      fw.push_back(d);
      f_err |= er;
      if (e) begin push_expected(); f_open = 0; end
    end
  endtask

  task automatic beat(input logic [31:0] d, input bit s, input bit e, input bit er);
    int t = 0;
    bit r = 0;
    bus.data_in = d; bus.sop = s; bus.eop = e; bus.err = er;
    bus.empty = 2'($urandom); bus.valid = 1'b1;
    forever begin
      @(negedge clk); r = bus.ready;
      @(posedge clk); #1;
      if (r) break;
      t++;
      if (t > 100) begin
        n_cmp++; n_bad++;
        $display("FAIL ready_timeout: got ready=0 for %0d cycles expected ready=1", t);
        break;
      end
    end
    if (r) model_beat(d, s, e, er);
    bus.valid = 1'b0; bus.sop = 1'b0; bus.eop = 1'b0; bus.err = 1'b0;
    repeat ($urandom % 3) begin @(posedge clk); #1; end
  endtask

  task automatic mk(input logic [15:0] et, input logic [3:0] ihl, input logic [7:0] proto,
                    input logic [47:0] dm, input logic [47:0] sm, input logic [31:0] sip,
                    input logic [31:0] dip, input logic [15:0] sp, input logic [15:0] dp);
    for (int i = 0; i < 64; i++) fb[i] = 8'($urandom);
    {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]} = dm;
    {fb[6], fb[7], fb[8], fb[9], fb[10], fb[11]} = sm;
    {fb[12], fb[13]} = et;
    fb[14] = {4'h4, ihl};
    fb[23] = proto;
    {fb[26], fb[27], fb[28], fb[29]} = sip;
    {fb[30], fb[31], fb[32], fb[33]} = dip;
    {fb[34], fb[35]} = sp;
    {fb[36], fb[37]} = dp;
  endtask

  // stop_after >= 0 sends only that many leading words (no eop), leaving the frame open.
  task automatic send_frame(input int n, input int err_idx, input int stop_after);
    for (int i = 0; i < n; i++) begin
      if (stop_after >= 0 && i == stop_after) break;
      beat({fb[4*i], fb[4*i+1], fb[4*i+2], fb[4*i+3]}, i == 0, i == n - 1, i == err_idx);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: compares each new record, checks it holds steady, then acknowledges.
  initial begin
    rec_t e;
    logic [214:0] held = '0;
    bit prev = 0;
    int hold = 0;
    bus.hdr_ack = 1'b0;
    forever begin
      @(negedge clk);
      bus.hdr_ack = 1'b0;
      if (!n_rst) begin prev = 0; continue; end
      if (bus.hdr_valid) begin
        if (!prev) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_record: got hdr_valid=1 expected no record");
            hold = 0;
          end else begin
            e = exp_q.pop_front();
            check("latency_cycle", 64'(cyc), 64'(e.cyc));
            check("hdr_err", 64'(bus.hdr_err), 64'(e.herr));
            check("is_ipv4", 64'(bus.is_ipv4), 64'(e.ipv4));
            check("has_ports", 64'(bus.has_ports), 64'(e.ports));
            check("match_mac", 64'(bus.match_mac), 64'(e.mm));
            check("match_ip", 64'(bus.match_ip), 64'(e.mi));
            check("match_port", 64'(bus.match_port), 64'(e.mp));
            if (!e.herr) begin
              check("dst_mac", 64'(bus.dst_mac), 64'(e.dmac));
              check("src_mac", 64'(bus.src_mac), 64'(e.smac));
              check("ethertype", 64'(bus.ethertype), 64'(e.et));
            end
            if (e.ipv4) begin
              check("src_ip", 64'(bus.src_ip), 64'(e.sip));
              check("dst_ip", 64'(bus.dst_ip), 64'(e.dip));
            end
            if (e.ports) begin
              check("src_port", 64'(bus.src_port), 64'(e.sp));
              check("dst_port", 64'(bus.dst_port), 64'(e.dp));
            end
            hold = (ack_delay_next >= 0) ? ack_delay_next : int'($urandom % 4);
            ack_delay_next = -1;
          end
          held = snap();
        end else begin
          check_snap("record_stable", snap(), held);
        end
        check("ready_low_while_held", 64'(bus.ready), 64'd0);
        if (hold == 0) bus.hdr_ack = 1'b1;
        else hold--;
      end else if ($urandom % 8 == 0) begin
        bus.hdr_ack = 1'b1;
      end
      prev = bus.hdr_valid;
    end
  end

  initial begin
    int kind, n;
    logic [47:0] dm, sm;
    logic [31:0] sip, dip;
    logic [15:0] sp, dp;
    bus.valid = 1'b0; bus.sop = 1'b0; bus.eop = 1'b0; bus.err = 1'b0;
    bus.data_in = '0; bus.empty = '0;

    repeat (2) @(negedge clk);
    check_snap("reset_outputs", snap(), '0);
    @(posedge clk); #1; n_rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(bus.ready), 64'd1);
    @(posedge clk); #1;

    // IPv4/UDP 16 words, all flags hit
    mk(16'h0800, 4'd5, 8'd17, 48'h001122334455, 48'h66778899aabb, 32'h0a000001,
       32'h0a000002, 16'h1234, 16'h0035);
    flagged_mac = 48'h001122334455; flagged_ip = 32'h0a000001; flagged_port = 16'h0035;
    send_frame(16, -1, -1);

    // ARP, 15 words
    mk(16'h0806, 4'd5, 8'd17, 48'hffffffffffff, 48'h001122334455, 32'h0a000001,
       32'h0a000001, 16'h0035, 16'h0035);
    send_frame(15, -1, -1);

    // runt: 3 words
    mk(16'h0800, 4'd5, 8'd6, 48'h001122334455, 48'h001122334455, 32'h0a000001,
       32'h0a000001, 16'h0035, 16'h0035);
    send_frame(3, -1, -1);

    // record held while the next frame waits
    idle(10);
    ack_delay_next = 5;
    mk(16'h0800, 4'd5, 8'd6, 48'h0a0b0c0d0e0f, 48'h001122334455, 32'hc0a80001,
       32'h0a000001, 16'h0035, 16'h0050);
    send_frame(12, -1, -1);
    mk(16'h0800, 4'd5, 8'd17, 48'h0a0b0c0d0e0f, 48'h102030405060, 32'hc0a80001,
       32'hc0a80002, 16'h0035, 16'h0050);
    send_frame(16, -1, -1);

    // sop at w5 aborts the first frame; err on a payload beat of the second
    mk(16'h0800, 4'd5, 8'd17, 48'h001122334455, 48'h1, 32'h0a000001, 32'h2, 16'h3, 16'h0035);
    send_frame(16, -1, 5);
    mk(16'h0800, 4'd5, 8'd17, 48'h001122334455, 48'h1, 32'h0a000001, 32'h2, 16'h3, 16'h0035);
    send_frame(16, 12, -1);

    // reset pulse mid-frame at w6
    idle(10);
    mk(16'h0800, 4'd5, 8'd17, 48'h001122334455, 48'h1, 32'h0a000001, 32'h2, 16'h3, 16'h0035);
    send_frame(16, -1, 6);
    n_rst = 1'b0; f_open = 0;
    @(negedge clk);
    check_snap("midframe_reset_outputs", snap(), '0);
    check("midframe_reset_ready", 64'(bus.ready), 64'd1);
    @(posedge clk); #1; n_rst = 1'b1;
    idle(2);
    send_frame(16, -1, -1);

    for (int f = 0; f < 40; f++) begin
      kind = int'($urandom % 4);
      n    = int'($urandom_range(1, 16));
      dm = 48'({$urandom, $urandom}); sm = 48'({$urandom, $urandom});
      sip = $urandom; dip = $urandom; sp = 16'($urandom); dp = 16'($urandom);
      mk((kind == 2) ? 16'h0806 : 16'h0800,
         (kind == 3) ? 4'($urandom_range(4, 6)) : 4'd5,
         (kind == 0) ? 8'd17 : (kind == 1) ? 8'd6 : 8'($urandom_range(5, 18)),
         dm, sm, sip, dip, sp, dp);
      flagged_mac  = ($urandom % 3 == 0) ? dm : ($urandom % 2 == 0) ? sm : 48'({$urandom, $urandom});
      flagged_ip   = ($urandom % 3 == 0) ? sip : ($urandom % 2 == 0) ? dip : $urandom;
      flagged_port = ($urandom % 3 == 0) ? sp : ($urandom % 2 == 0) ? dp : 16'($urandom);
      if ($urandom % 4 == 0) beat($urandom, 1'b0, 1'($urandom), 1'b0);
      if ($urandom % 6 == 0) send_frame(16, -1, int'($urandom_range(1, 12)));
      send_frame(n, ($urandom % 6 == 0) ? int'($urandom % n) : -1, -1);
    end

    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
    idle(10);
    check("records_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
